bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
Parametrised multi-digit up/down counter. Each digit is a 4-bit nibble that counts modulo MOD, and digits are cascaded through an internal carry/borrow chain. It generalises the single-decade 0..9 counter and adds:
- synchronous load
- saturate or wrap mode
- terminal-count flag
- overflow and underflow pulses

It sits between the enable/pulse generator and the seven-segment display driver.

Parameters:
N_DIGITS, 2, number of cascaded digits (1..8); cnt_o is 4*N_DIGITS bits wide.
MOD, 10, modulus of every digit (2..16); each digit holds 0..MOD-1.

Ports:
clk_i  input  1  system clock, rising-edge active
rst_ni  input  1  reset, asynchronous, active-low
ena_i  input  1  count enable, one step per rising edge while high
updown_i  input  1  direction: 1 = count up, 0 = count down
load_i  input  1  synchronous load of load_val_i
load_val_i  input  4*N_DIGITS  load value, digit 0 in bits [3:0]
sat_i  input  1  mode: 1 = saturate at limits, 0 = wrap
cnt_o  output  4*N_DIGITS  registered count, digit k in bits [4k+3:4k]
tc_o  output  1  combinational terminal count; see Behaviour
ovf_o  output  1  registered one-cycle pulse on an up step at maximum
unf_o  output  1  registered one-cycle pulse on a down step at zero

Behaviour:
- Reset: rst_ni low clears cnt_o, ovf_o and unf_o to 0 immediately, without waiting for a clock edge.
  - Reset mid-count takes precedence over everything.
  - The first count after release happens on the first rising edge with rst_ni high and ena_i high.
- Priority at each rising edge: load_i, then ena_i, then hold.
- Load:
  - cnt_o <= load_val_i, with each digit clamped independently; any nibble >= MOD loads as MOD-1.
  - ovf_o and unf_o are 0 that cycle; ena_i and updown_i are ignored.
- Latency: cnt_o changes on the same rising edge that samples ena_i = 1.
  - ovf_o and unf_o are high for exactly the cycle following that edge.
- Up step, per digit k:
  - Digit 0 always steps; digit k steps only if digits 0..k-1 all equal MOD-1.
  - A stepping digit at MOD-1 becomes 0; otherwise it increments by 1.
- Down step, per digit k:
  - Digit k steps only if digits 0..k-1 all equal 0.
  - A stepping digit at 0 becomes MOD-1; otherwise it decrements by 1.
- Maximum means every digit = MOD-1; zero means every digit = 0.
- Up step at maximum:
  - sat_i = 0: cnt_o wraps to all zeros and ovf_o pulses.
  - sat_i = 1: cnt_o holds maximum and ovf_o still pulses.
- Down step at zero:
  - sat_i = 0: cnt_o wraps to maximum and unf_o pulses.
  - sat_i = 1: cnt_o holds zero and unf_o still pulses.
- ovf_o and unf_o are never both high. Both are 0 in any cycle with no enabled step.
- tc_o = ena_i & ~load_i & ((updown_i & cnt==max) | (~updown_i & cnt==0)).
  - It is purely combinational and intended for cascading further counters.
- updown_i and sat_i may change every cycle; only the values sampled at the edge matter.
- A digit can never hold a value >= MOD.
- No other internal state: the carry/borrow chain is combinational from the current cnt_o.

Test Plan (N_DIGITS=2, MOD=10 unless stated):
1. Reset and hold: rst_ni=0 for 2 cycles, then release with ena_i=0 for 3 cycles -> cnt_o=0x00, ovf_o=unf_o=0 throughout; assert rst_ni low asynchronously between edges -> cnt_o=0x00 before the next edge.
2. Up carry and wrap: sat_i=0, updown_i=1, ena_i=1 for 100 cycles from 0x00 -> 0x09 then 0x10 at step 10; 0x99 at step 99; step 100 -> 0x00 with ovf_o=1 for one cycle only; tc_o=1 only while cnt_o=0x99.
3. Down borrow and wrap: load 0x10, then updown_i=0 with 2 steps -> 0x09, 0x08; load 0x00 and step down -> 0x99 with unf_o pulse; toggle ena_i 1/0 alternately -> count changes only on enabled edges.
4. Saturate: sat_i=1, load 0x98, step up 3 times -> 0x99, 0x99, 0x99 with ovf_o high after steps 2 and 3; load 0x01, step down 3 times -> 0x00, 0x00, 0x00 with unf_o high after steps 2 and 3.
5. Load priority and clamping: load_i=1 and ena_i=1 with load_val_i=0xF3 -> cnt_o=0x93, no step applied, ovf_o=unf_o=0, tc_o=0 that cycle.
6. Parameter sweep, N_DIGITS=3 and MOD=6: count up from 0 -> 0x005 then 0x010; 216 up steps from 0 -> 0x000 with ovf_o pulse; reset mid-count at 0x123 -> 0x000.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Multi-digit up/down counter: every 4-bit digit counts modulo MOD, and the digits are
// cascaded through a combinational carry/borrow chain. Also supports load, saturate and terminal-count.
module bcd_updown_counter #(
  parameter int N_DIGITS = 2,
  parameter int MOD      = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ena_i,
  input  logic                    updown_i,
  input  logic                    load_i,
  input  logic [4*N_DIGITS-1:0]   load_val_i,
  input  logic                    sat_i,
  output logic [4*N_DIGITS-1:0]   cnt_o,
  output logic                    tc_o,
  output logic                    ovf_o,
  output logic                    unf_o
);

  localparam int         W    = 4 * N_DIGITS;
  localparam logic [4:0] MOD5 = 5'(MOD);
  localparam logic [3:0] DMAX = 4'(MOD - 1);

  logic [W-1:0] up_nxt;
  logic [W-1:0] dn_nxt;
  logic [W-1:0] load_clamped;
  logic         at_max;
  logic         at_zero;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    if ({1'b0, d} >= MOD5) return DMAX;
    return d;
  endfunction

  // Ripple chain: a digit steps only when every lower digit is at its limit.
  always_comb begin
    logic       c_up;
    logic       c_dn;
    logic [3:0] d;
    up_nxt       = cnt_o;
    dn_nxt       = cnt_o;
    load_clamped = '0;
    c_up         = 1'b1;
    c_dn         = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      d = cnt_o[4*k +: 4];
      if (c_up) up_nxt[4*k +: 4] = (d == DMAX) ? 4'd0 : 4'(d + 4'd1);
      if (c_dn) dn_nxt[4*k +: 4] = (d == 4'd0) ? DMAX : 4'(d - 4'd1);
      c_up = c_up & (d == DMAX);
      c_dn = c_dn & (d == 4'd0);
      load_clamped[4*k +: 4] = clamp_digit(load_val_i[4*k +: 4]);
    end
    at_max  = c_up;
    at_zero = c_dn;
  end

  assign tc_o = ena_i & ~load_i & ((updown_i & at_max) | (~updown_i & at_zero));

  // Register stage: load beats enable; saturation only suppresses the wrap, not the pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else if (load_i) begin
      cnt_o <= load_clamped;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else if (ena_i) begin
      if (updown_i) begin
        cnt_o <= (at_max && sat_i) ? cnt_o : up_nxt;
        ovf_o <= at_max;
        unf_o <= 1'b0;
      end else begin
        cnt_o <= (at_zero && sat_i) ? cnt_o : dn_nxt;
        ovf_o <= 1'b0;
        unf_o <= at_zero;
      end
    end else begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Randomized self-checking bench for bcd_updown_counter against an integer-valued model,
// covering a 2-digit decimal instance and a 3-digit modulo-6 instance.
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance A: N_DIGITS=2, MOD=10
  logic       rst_na, ena_a, ud_a, load_a, sat_a;
  logic [7:0] lv_a, cnt_a;
  logic       tc_a, ovf_a, unf_a;
  // Instance B: N_DIGITS=3, MOD=6
  logic        rst_nb, ena_b, ud_b, load_b, sat_b;
  logic [11:0] lv_b, cnt_b;
  logic        tc_b, ovf_b, unf_b;

  bcd_updown_counter #(.N_DIGITS(2), .MOD(10)) dut_a (
    .clk_i(clk), .rst_ni(rst_na), .ena_i(ena_a), .updown_i(ud_a), .load_i(load_a),
    .load_val_i(lv_a), .sat_i(sat_a), .cnt_o(cnt_a), .tc_o(tc_a), .ovf_o(ovf_a), .unf_o(unf_a));

  bcd_updown_counter #(.N_DIGITS(3), .MOD(6)) dut_b (
    .clk_i(clk), .rst_ni(rst_nb), .ena_i(ena_b), .updown_i(ud_b), .load_i(load_b),
    .load_val_i(lv_b), .sat_i(sat_b), .cnt_o(cnt_b), .tc_o(tc_b), .ovf_o(ovf_b), .unf_o(unf_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model keeps the count as one integer in 0 .. MOD**N-1; digits only appear when packing.
  function automatic int total(input int nd, input int md);
    int t = 1;
    for (int i = 0; i < nd; i++) t = t * md;
    return t;
  endfunction

  function automatic logic [31:0] pack(input int v, input int nd, input int md);
    logic [31:0] p = '0;
    int r = v;
    for (int i = 0; i < nd; i++) begin
      p[4*i +: 4] = 4'(r % md);
      r = r / md;
    end
    return p;
  endfunction

  function automatic int unpack_clamped(input logic [31:0] p, input int nd, input int md);
    int v = 0;
    int nib;
    for (int i = nd - 1; i >= 0; i--) begin
      nib = int'(p[4*i +: 4]);
      if (nib >= md) nib = md - 1;
      v = v * md + nib;
    end
    return v;
  endfunction

  task automatic model_step(input int nd, input int md, inout int v, output bit o, output bit u,
                            input bit ld, input logic [31:0] lv, input bit en, input bit ud, input bit st);
    int t = total(nd, md);
    o = 1'b0;
    u = 1'b0;
    if (ld) v = unpack_clamped(lv, nd, md);
    else if (en && ud) begin
      if (v == t - 1) begin o = 1'b1; v = st ? v : 0; end
      else v = v + 1;
    end else if (en) begin
      if (v == 0) begin u = 1'b1; v = st ? 0 : t - 1; end
      else v = v - 1;
    end
  endtask

  int mv_a = 0, mv_b = 0;
  bit mo, mu;

  task automatic cyc_a(input bit ld, input logic [7:0] lv, input bit en, input bit ud, input bit st);
    bit etc;
    load_a = ld; lv_a = lv; ena_a = en; ud_a = ud; sat_a = st;
    #1;
    etc = en && !ld && (ud ? (mv_a == 99) : (mv_a == 0));
    chk("tc_a", 32'(tc_a), 32'(etc));
    @(posedge clk);
    model_step(2, 10, mv_a, mo, mu, ld, 32'(lv), en, ud, st);
    @(negedge clk);
    chk("cnt_a", 32'(cnt_a), pack(mv_a, 2, 10));
    chk("ovf_a", 32'(ovf_a), 32'(mo));
    chk("unf_a", 32'(unf_a), 32'(mu));
  endtask

  task automatic cyc_b(input bit ld, input logic [11:0] lv, input bit en, input bit ud, input bit st);
    bit etc;
    load_b = ld; lv_b = lv; ena_b = en; ud_b = ud; sat_b = st;
    #1;
    etc = en && !ld && (ud ? (mv_b == 215) : (mv_b == 0));
    chk("tc_b", 32'(tc_b), 32'(etc));
    @(posedge clk);
    model_step(3, 6, mv_b, mo, mu, ld, 32'(lv), en, ud, st);
    @(negedge clk);
    chk("cnt_b", 32'(cnt_b), pack(mv_b, 3, 6));
    chk("ovf_b", 32'(ovf_b), 32'(mo));
    chk("unf_b", 32'(unf_b), 32'(mu));
  endtask

  initial begin
    rst_na = 1'b0; ena_a = 0; ud_a = 0; load_a = 0; lv_a = '0; sat_a = 0;
    rst_nb = 1'b0; ena_b = 0; ud_b = 0; load_b = 0; lv_b = '0; sat_b = 0;

    // Reset and hold
    repeat (2) begin
      @(negedge clk);
      chk("rst_cnt", 32'(cnt_a), 32'h00);
      chk("rst_flags", 32'({ovf_a, unf_a}), 32'h0);
    end
    rst_na = 1'b1; rst_nb = 1'b1;
    repeat (3) cyc_a(0, 8'h00, 0, 1, 0);

    // Up count with carry and wrap
    for (int i = 1; i <= 100; i++) begin
      cyc_a(0, 8'h00, 1, 1, 0);
      if (i == 10)  chk("up_10", 32'(cnt_a), 32'h10);
      if (i == 99)  chk("up_99", 32'(cnt_a), 32'h99);
      if (i == 100) chk("wrap_ovf", 32'({cnt_a, ovf_a}), 32'h001);
    end
    cyc_a(0, 8'h00, 0, 1, 0);
    chk("ovf_once", 32'(ovf_a), 32'h0);

    // Down borrow and wrap
    cyc_a(1, 8'h10, 0, 0, 0);
    cyc_a(0, 8'h00, 1, 0, 0);
    chk("dn_09", 32'(cnt_a), 32'h09);
    cyc_a(0, 8'h00, 1, 0, 0);
    chk("dn_08", 32'(cnt_a), 32'h08);
    cyc_a(1, 8'h00, 0, 0, 0);
    cyc_a(0, 8'h00, 1, 0, 0);
    chk("dn_wrap", 32'({cnt_a, unf_a}), 32'h133);
    for (int i = 0; i < 6; i++) cyc_a(0, 8'h00, (i % 2) == 0, 0, 0);

    // Saturate
    cyc_a(1, 8'h98, 0, 1, 1);
    repeat (3) cyc_a(0, 8'h00, 1, 1, 1);
    chk("sat_hi", 32'({cnt_a, ovf_a}), 32'h133);
    cyc_a(1, 8'h01, 0, 0, 1);
    repeat (3) cyc_a(0, 8'h00, 1, 0, 1);
    chk("sat_lo", 32'({cnt_a, unf_a}), 32'h001);

    // Load priority over enable, with per-digit clamping
    cyc_a(1, 8'hF3, 1, 1, 0);
    chk("load_clamp", 32'(cnt_a), 32'h93);

    // Randomized traffic, loads biased toward the limits
    for (int i = 0; i < 400; i++) begin
      logic [7:0] lv;
      lv = 8'($urandom);
      if ($urandom_range(0, 3) == 0) lv = ($urandom_range(0, 1) != 0) ? 8'h99 : 8'h00;
      cyc_a($urandom_range(0, 15) == 0, lv, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
    end

    // Asynchronous reset between edges
    cyc_a(1, 8'h57, 0, 1, 0);
    #2;
    rst_na = 1'b0;
    #1;
    chk("async_rst", 32'({cnt_a, ovf_a, unf_a}), 32'h0);
    mv_a = 0;
    @(negedge clk);
    rst_na = 1'b1;
    cyc_a(0, 8'h00, 1, 1, 0);
    chk("first_after_rst", 32'(cnt_a), 32'h01);

    // Three-digit modulo-6 instance
    for (int i = 1; i <= 216; i++) begin
      cyc_b(0, 12'h000, 1, 1, 0);
      if (i == 5)   chk("b_005", 32'(cnt_b), 32'h005);
      if (i == 6)   chk("b_010", 32'(cnt_b), 32'h010);
      if (i == 216) chk("b_wrap", 32'({cnt_b, ovf_b}), 32'h0001);
    end
    for (int i = 0; i < 200; i++)
      cyc_b($urandom_range(0, 15) == 0, 12'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
    cyc_b(1, 12'h123, 0, 1, 0);
    chk("b_load", 32'(cnt_b), 32'h123);
    #2;
    rst_nb = 1'b0;
    #1;
    chk("b_rst", 32'(cnt_b), 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
